// File: rtl/pulse_generator.sv
// Retriggerable pulse-train generator: HIGH_CYCLES high then LOW_CYCLES low per request,
// with a saturating queue of pending requests and a sticky overflow flag.
module pulse_generator #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              clr_ovf,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [15:0]       HIGH_LAST = 16'(HIGH_CYCLES - 1);
  localparam logic [15:0]       LOW_LAST  = 16'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  state_t            state, state_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              ovf_set;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    pend_nxt  = pending;
    ovf_set   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (trig) state_nxt = HIGH;
      end
      HIGH: begin
        if (trig) begin
          if (pending == PEND_MAX) ovf_set = 1'b1;
          else                     pend_nxt = pending + PEND_ONE;
        end
        if (cnt == HIGH_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (cnt == LOW_LAST) begin
          cnt_nxt = '0;
          // A trig here is consumed by the next pulse, so pending nets to unchanged
          // and a saturated queue cannot overflow on this cycle.
          if (trig) begin
            state_nxt = HIGH;
          end else if (pending != '0) begin
            state_nxt = HIGH;
            pend_nxt  = pending - PEND_ONE;
          end else begin
            state_nxt = IDLE;
          end
        end else if (trig) begin
          if (pending == PEND_MAX) ovf_set = 1'b1;
          else                     pend_nxt = pending + PEND_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      out     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pend_nxt;
      out     <= (state_nxt == HIGH);
      ovf     <= ovf_set | (ovf & ~clr_ovf);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_generator.sv
// Bench for pulse_generator: vector table, directed corner sequences, and random traffic
// compared against a pulse-position reference model.
module tb_pulse_generator;
  localparam int H = 4, L = 2, PW = 3, PMAX = 7;

  logic          clk = 1'b0, rst_n = 1'b0, trig = 1'b0, clr_ovf = 1'b0;
  logic          out, busy, ovf;
  logic [PW-1:0] pending;

  int total = 0, bad = 0;

  // Reference: active pulse, position within the H+L cycle pulse, queue depth, sticky flag.
  bit m_act, m_ovf;
  int m_pos, m_pend;

  typedef struct {
    bit t; bit c; bit eo; bit eb; int ep; bit eov;
  } vec_t;
  vec_t tbl[20];

  pulse_generator #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .PEND_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .clr_ovf(clr_ovf),
    .out(out), .busy(busy), .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_act = 0; m_pos = 0; m_pend = 0; m_ovf = 0;
  endtask

  task automatic m_step(input bit t, input bit c);
    bit set;
    int p;
    set = 0;
    if (!m_act) begin
      if (t) begin m_act = 1; m_pos = 0; end
    end else if (m_pos == H + L - 1) begin
      p = m_pend + int'(t);
      if (p > 0) begin m_pos = 0; m_pend = p - 1; end
      else m_act = 0;
    end else begin
      m_pos++;
      if (t) begin
        if (m_pend == PMAX) set = 1;
        else m_pend++;
      end
    end
    m_ovf = set | (m_ovf & !c);
  endtask

  task automatic chk_model();
    check("model_out", out, (m_act && m_pos < H));
    check("model_busy", busy, m_act);
    check("model_pending", pending, m_pend);
    check("model_ovf", ovf, m_ovf);
  endtask

  task automatic step(input bit t, input bit c);
    trig = t; clr_ovf = c;
    if (rst_n) m_step(t, c);
    @(posedge clk); #1;
    chk_model();
  endtask

  function automatic vec_t v(input bit t, c, eo, eb, input int ep, input bit eov);
    vec_t r;
    r.t = t; r.c = c; r.eo = eo; r.eb = eb; r.ep = ep; r.eov = eov;
    return r;
  endfunction

  initial begin
    int busy_cyc, rises, dens, guard;
    bit prev;

    // single pulse, then two requests two cycles apart
    tbl[0] = v(1,0,1,1,0,0);
    for (int i = 1; i < 4; i++) tbl[i] = v(0,0,1,1,0,0);
    tbl[4] = v(0,0,0,1,0,0); tbl[5] = v(0,0,0,1,0,0);
    tbl[6] = v(0,0,0,0,0,0);
    tbl[7] = v(1,0,1,1,0,0); tbl[8] = v(0,0,1,1,0,0);
    tbl[9] = v(1,0,1,1,1,0); tbl[10] = v(0,0,1,1,1,0);
    tbl[11] = v(0,0,0,1,1,0); tbl[12] = v(0,0,0,1,1,0);
    for (int i = 13; i < 17; i++) tbl[i] = v(0,0,1,1,0,0);
    tbl[17] = v(0,0,0,1,0,0); tbl[18] = v(0,0,0,1,0,0);
    tbl[19] = v(0,0,0,0,0,0);

    m_reset();
    #1;
    check("rst_out", out, 0); check("rst_busy", busy, 0);
    check("rst_pending", pending, 0); check("rst_ovf", ovf, 0);
    for (int i = 0; i < 8; i++) step(1'($urandom), 1'($urandom));
    rst_n = 1'b1;
    step(0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].t, tbl[i].c);
      check($sformatf("vec%0d_out", i), out, tbl[i].eo);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
      check($sformatf("vec%0d_pending", i), pending, tbl[i].ep);
      check($sformatf("vec%0d_ovf", i), ovf, tbl[i].eov);
    end

    // Overflow: the last-GAP cycle of pulse 1 absorbs one request, so 9 trigs reach 7
    // and the 10th overflows.
    for (int i = 0; i < 10; i++) begin
      step(1, 0);
      if (i == 8) begin
        check("ovf9_pending", pending, 7); check("ovf9_flag", ovf, 0);
      end
    end
    check("ovf10_pending", pending, 7); check("ovf10_flag", ovf, 1);
    step(0, 1);
    check("ovf_clr", ovf, 0);
    busy_cyc = 0; rises = 0; prev = out;
    for (int k = 0; k < 100; k++) begin
      step(0, 0);
      if (out && !prev) rises++;
      prev = out;
      if (!busy) break;
      busy_cyc++;
    end
    check("queue_busy_cycles", busy_cyc, 1 + 7 * (H + L));
    check("queue_pulses", rises, 7);

    // trig on the last GAP cycle with an empty queue
    step(1, 0);
    for (int i = 0; i < 5; i++) step(0, 0);
    step(1, 0);
    check("lastgap_out", out, 1); check("lastgap_pending", pending, 0);
    check("lastgap_busy", busy, 1);
    guard = 0;
    while (pending != 3'd7 && guard < 50) begin step(1, 0); guard++; end
    check("fill_guard", (guard < 50), 1);
    step(1, 0);
    check("sat_ovf", ovf, 1);
    step(1, 1);
    check("clr_vs_set", ovf, 1);
    step(0, 1);
    check("clr_after", ovf, 0);

    rst_n = 1'b0; m_reset();
    step(0, 0);
    rst_n = 1'b1;

    // reset in the 2nd HIGH cycle with three queued requests
    for (int i = 0; i < 5; i++) step(1, 0);
    step(0, 0); step(0, 0);
    check("pre_rst_pending", pending, 3); check("pre_rst_out", out, 1);
    #2 rst_n = 1'b0; m_reset();
    #1;
    check("async_out", out, 0); check("async_pending", pending, 0);
    check("async_busy", busy, 0); check("async_ovf", ovf, 0);
    step(1, 0);
    rst_n = 1'b1;
    step(1, 0);
    check("post_rst_out", out, 1); check("post_rst_pending", pending, 0);
    for (int i = 0; i < 6; i++) step(0, 0);
    check("post_rst_idle", busy, 0);

    // random traffic with varying request density
    dens = 2;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) dens = $urandom_range(1, 8);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0; m_reset();
        step(1'($urandom), 0);
        rst_n = 1'b1;
      end
      step(($urandom_range(0, 8) < dens), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
